// File: rtl/tboom_rename_pkg.sv
// Shared rename-stage types: checkpoint depth, branch tag/mask types and
// the checkpoint controller state encoding.
package tboom_rename_pkg;

  localparam int CHECKPOINT_DEPTH = 8;
  localparam int BR_TAG_W         = $clog2(CHECKPOINT_DEPTH);

  typedef logic [BR_TAG_W-1:0]         br_tag_t;
  typedef logic [CHECKPOINT_DEPTH-1:0] br_mask_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RESTORE = 2'd1,
    RECOVER = 2'd2
  } ckpt_state_e;

endpackage

// File: rtl/tboom_circ_range_mask.sv
// Circular inclusive-exclusive range mask over a power-of-two ring:
// bit i is set when i lies in [start_i, end_i). start_i == end_i means the whole ring.
module tboom_circ_range_mask #(
  parameter int DEPTH = 8,
  parameter int W     = $clog2(DEPTH)
) (
  input  logic [W-1:0]     start_i,
  input  logic [W-1:0]     end_i,
  output logic [DEPTH-1:0] mask_o
);

  logic [W-1:0] len;
  logic [W-1:0] off;

  always_comb begin
    mask_o = '0;
    off    = '0;
    len    = end_i - start_i;
    for (int i = 0; i < DEPTH; i++) begin
      off       = W'(i) - start_i;
      mask_o[i] = (len == '0) || (off < len);
    end
  end

endmodule

// File: rtl/tboom_rmt_checkpoint_ctrl.sv
// RMT checkpoint slot allocator / mispredict recovery sequencer.
// Optional saturating perf counters when TBOOM_CKPT_PERF_EN is defined.
module tboom_rmt_checkpoint_ctrl
  import tboom_rename_pkg::*;
#(
  parameter int CHECKPOINT_DEPTH = tboom_rename_pkg::CHECKPOINT_DEPTH,
  parameter int RECOVERY_CYCLES  = 2,
  parameter int TAG_W            = $clog2(CHECKPOINT_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        br_alloc_valid,
  output logic                        br_alloc_ready,
  output logic [TAG_W-1:0]            br_alloc_tag,
  input  logic                        resolve_valid,
  input  logic [TAG_W-1:0]            resolve_tag,
  input  logic                        resolve_mispredict,
  output logic                        rmt_checkpoint,
  output logic                        rmt_restore,
  output logic [TAG_W-1:0]            rmt_pos,
  output logic                        rename_stall,
  output logic                        kill_valid,
  output logic [CHECKPOINT_DEPTH-1:0] kill_mask,
  output logic [CHECKPOINT_DEPTH-1:0] busy_mask
`ifdef TBOOM_CKPT_PERF_EN
  ,
  output logic [31:0]                 perf_mispredicts,
  output logic [31:0]                 perf_full_stalls
`endif
);

  localparam int CNT_W = $clog2(RECOVERY_CYCLES + 1);

  ckpt_state_e                 state_q, state_d;
  logic [CHECKPOINT_DEPTH-1:0] busy_q, busy_d;
  logic [TAG_W-1:0]            tail_q, tail_d;
  logic [TAG_W-1:0]            pending_q, pending_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        rmt_restore_q, rmt_restore_d;
  logic                        kill_valid_q, kill_valid_d;
  logic [CHECKPOINT_DEPTH-1:0] kill_mask_q, kill_mask_d;
  logic                        rename_stall_q, rename_stall_d;

  logic [CHECKPOINT_DEPTH-1:0] squash_mask;
  logic                        mispredict_accept;
  logic                        correct_free;
  logic                        alloc_fire;

  // Squashed tags: the mispredicted branch and everything younger up to tail.
  // tag == tail with tag busy can only mean a full ring, which the helper maps to all ones.
  tboom_circ_range_mask #(
    .DEPTH (CHECKPOINT_DEPTH),
    .W     (TAG_W)
  ) u_squash_mask (
    .start_i (resolve_tag),
    .end_i   (tail_q),
    .mask_o  (squash_mask)
  );

  assign mispredict_accept = resolve_valid &  resolve_mispredict & busy_q[resolve_tag];
  assign correct_free      = resolve_valid & !resolve_mispredict & busy_q[resolve_tag];

  assign br_alloc_ready = (state_q == RUN) & !busy_q[tail_q] & !mispredict_accept;
  assign br_alloc_tag   = tail_q;
  assign alloc_fire     = br_alloc_valid & br_alloc_ready;

  assign rmt_checkpoint = alloc_fire;
  assign rmt_restore    = rmt_restore_q;
  assign rmt_pos        = rmt_restore_q ? pending_q : tail_q;
  assign rename_stall   = rename_stall_q;
  assign kill_valid     = kill_valid_q;
  assign kill_mask      = kill_mask_q;
  assign busy_mask      = busy_q;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    tail_d      = tail_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    kill_mask_d = '0;

    if (correct_free) begin
      busy_d[resolve_tag] = 1'b0;
    end
    if (alloc_fire) begin
      busy_d[tail_q] = 1'b1;
      tail_d         = tail_q + TAG_W'(1);
    end

    case (state_q)
      RUN: ;
      RESTORE: begin
        state_d = RECOVER;
        cnt_d   = CNT_W'(RECOVERY_CYCLES);
      end
      RECOVER: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    // An accepted mispredict overrides everything above, including a pending recovery.
    if (mispredict_accept) begin
      busy_d      = busy_d & ~squash_mask;
      tail_d      = resolve_tag;
      pending_d   = resolve_tag;
      state_d     = RESTORE;
      kill_mask_d = squash_mask;
    end

    rmt_restore_d  = (state_d == RESTORE);
    kill_valid_d   = (state_d == RESTORE);
    rename_stall_d = (state_d != RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      busy_q         <= '0;
      tail_q         <= '0;
      pending_q      <= '0;
      cnt_q          <= '0;
      rmt_restore_q  <= 1'b0;
      kill_valid_q   <= 1'b0;
      kill_mask_q    <= '0;
      rename_stall_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      tail_q         <= tail_d;
      pending_q      <= pending_d;
      cnt_q          <= cnt_d;
      rmt_restore_q  <= rmt_restore_d;
      kill_valid_q   <= kill_valid_d;
      kill_mask_q    <= kill_mask_d;
      rename_stall_q <= rename_stall_d;
    end
  end

`ifdef TBOOM_CKPT_PERF_EN
  logic [31:0] perf_mis_q, perf_mis_d;
  logic [31:0] perf_full_q, perf_full_d;

  always_comb begin
    perf_mis_d  = perf_mis_q;
    perf_full_d = perf_full_q;
    if (mispredict_accept && (perf_mis_q != '1)) begin
      perf_mis_d = perf_mis_q + 32'd1;
    end
    if (br_alloc_valid && busy_q[tail_q] && (state_q == RUN) && (perf_full_q != '1)) begin
      perf_full_d = perf_full_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_mis_q  <= '0;
      perf_full_q <= '0;
    end else begin
      perf_mis_q  <= perf_mis_d;
      perf_full_q <= perf_full_d;
    end
  end

  assign perf_mispredicts = perf_mis_q;
  assign perf_full_stalls = perf_full_q;
`endif

endmodule

// File: tb/tb_tboom_rmt_checkpoint_ctrl.sv
// Scoreboard bench for the RMT checkpoint controller at DEPTH=4, RECOVERY_CYCLES=2.
// Grants and kill broadcasts are checked by a negedge monitor against expected queues.
module tb_tboom_rmt_checkpoint_ctrl;

  localparam int DEPTH = 4;
  localparam int TAG_W = 2;
  localparam int RC    = 2;

  logic             clk;
  logic             rst;
  logic             br_alloc_valid;
  logic             br_alloc_ready;
  logic [TAG_W-1:0] br_alloc_tag;
  logic             resolve_valid;
  logic [TAG_W-1:0] resolve_tag;
  logic             resolve_mispredict;
  logic             rmt_checkpoint;
  logic             rmt_restore;
  logic [TAG_W-1:0] rmt_pos;
  logic             rename_stall;
  logic             kill_valid;
  logic [DEPTH-1:0] kill_mask;
  logic [DEPTH-1:0] busy_mask;

  tboom_rmt_checkpoint_ctrl #(
    .CHECKPOINT_DEPTH (DEPTH),
    .RECOVERY_CYCLES  (RC),
    .TAG_W            (TAG_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .br_alloc_valid     (br_alloc_valid),
    .br_alloc_ready     (br_alloc_ready),
    .br_alloc_tag       (br_alloc_tag),
    .resolve_valid      (resolve_valid),
    .resolve_tag        (resolve_tag),
    .resolve_mispredict (resolve_mispredict),
    .rmt_checkpoint     (rmt_checkpoint),
    .rmt_restore        (rmt_restore),
    .rmt_pos            (rmt_pos),
    .rename_stall       (rename_stall),
    .kill_valid         (kill_valid),
    .kill_mask          (kill_mask),
    .busy_mask          (busy_mask)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [TAG_W-1:0]       exp_grant_q[$];
  logic [DEPTH+TAG_W-1:0] exp_kill_q[$];   // {kill_mask, rmt_pos}
  logic [TAG_W-1:0]       g_exp;
  logic [DEPTH+TAG_W-1:0] k_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (br_alloc_valid && br_alloc_ready) begin
        if (exp_grant_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant actual=%0d required=none", br_alloc_tag);
        end else begin
          g_exp = exp_grant_q.pop_front();
          check("grant_tag", 32'(br_alloc_tag), 32'(g_exp));
          check("grant_ckpt", 32'(rmt_checkpoint), 32'd1);
          check("grant_pos", 32'(rmt_pos), 32'(g_exp));
        end
      end
      if (kill_valid) begin
        if (exp_kill_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_kill actual=%0h required=none", kill_mask);
        end else begin
          k_exp = exp_kill_q.pop_front();
          check("kill_mask", 32'(kill_mask), 32'(k_exp[DEPTH+TAG_W-1:TAG_W]));
          check("restore_pos", 32'(rmt_pos), 32'(k_exp[TAG_W-1:0]));
          check("restore_pulse", 32'(rmt_restore), 32'd1);
          check("restore_stall", 32'(rename_stall), 32'd1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic resolve(input logic [TAG_W-1:0] tag, input logic mp);
    resolve_valid      = 1'b1;
    resolve_tag        = tag;
    resolve_mispredict = mp;
    tick();
    resolve_valid      = 1'b0;
    resolve_mispredict = 1'b0;
  endtask

  task automatic alloc(input int n, input int first);
    for (int i = 0; i < n; i++) exp_grant_q.push_back(TAG_W'(first + i));
    br_alloc_valid = 1'b1;
    repeat (n) tick();
    br_alloc_valid = 1'b0;
  endtask

  task automatic push_kill(input logic [DEPTH-1:0] mask, input logic [TAG_W-1:0] pos);
    exp_kill_q.push_back({mask, pos});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst                = 1'b1;
    br_alloc_valid     = 1'b0;
    resolve_valid      = 1'b0;
    resolve_tag        = '0;
    resolve_mispredict = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    check("rst_busy", 32'(busy_mask), 32'h0);
    check("rst_ready", 32'(br_alloc_ready), 32'd1);
    check("rst_stall", 32'(rename_stall), 32'd0);
    check("rst_kill_valid", 32'(kill_valid), 32'd0);
    check("rst_restore", 32'(rmt_restore), 32'd0);
    check("rst_tag", 32'(br_alloc_tag), 32'd0);

    // Fill all four slots back-to-back, then hold valid while full.
    exp_grant_q.push_back(2'd0);
    exp_grant_q.push_back(2'd1);
    exp_grant_q.push_back(2'd2);
    exp_grant_q.push_back(2'd3);
    br_alloc_valid = 1'b1;
    repeat (4) tick();
    check("full_busy", 32'(busy_mask), 32'hF);
    check("full_ready", 32'(br_alloc_ready), 32'd0);
    check("full_ckpt", 32'(rmt_checkpoint), 32'd0);

    // Free tag 0 while full: freed slot is not reusable in the same cycle.
    exp_grant_q.push_back(2'd0);
    resolve_valid = 1'b1;
    resolve_tag   = 2'd0;
    #1;
    check("free_same_cycle_ready", 32'(br_alloc_ready), 32'd0);
    tick();
    resolve_valid = 1'b0;
    check("free_next_ready", 32'(br_alloc_ready), 32'd1);
    tick();
    // Out-of-order free behind tail does not unblock allocation.
    resolve(2'd2, 1'b0);
    check("hole_ready", 32'(br_alloc_ready), 32'd0);
    check("hole_busy", 32'(busy_mask), 32'hB);
    br_alloc_valid = 1'b0;

    // Mispredict tag 1 with tags 0-3 live and tail=0.
    do_reset();
    alloc(4, 0);
    push_kill(4'b1110, 2'd1);
    resolve(2'd1, 1'b1);
    check("mp1_restore", 32'(rmt_restore), 32'd1);
    check("mp1_busy", 32'(busy_mask), 32'h1);
    br_alloc_valid = 1'b1;
    exp_grant_q.push_back(2'd1);
    tick();
    check("rec1_stall", 32'(rename_stall), 32'd1);
    check("rec1_restore", 32'(rmt_restore), 32'd0);
    check("rec1_ready", 32'(br_alloc_ready), 32'd0);
    tick();
    check("rec2_stall", 32'(rename_stall), 32'd1);
    check("rec2_ready", 32'(br_alloc_ready), 32'd0);
    tick();
    check("run_stall", 32'(rename_stall), 32'd0);
    check("run_ready", 32'(br_alloc_ready), 32'd1);
    tick();
    br_alloc_valid = 1'b0;
    check("mp1_after_busy", 32'(busy_mask), 32'h3);

    // Wrap case: live tags 2,3,0 with tail=1, mispredict tag 3.
    resolve(2'd0, 1'b0);
    resolve(2'd1, 1'b0);
    alloc(3, 2);
    check("wrap_busy", 32'(busy_mask), 32'hD);
    push_kill(4'b1001, 2'd3);
    resolve(2'd3, 1'b1);
    check("wrap_after_busy", 32'(busy_mask), 32'h4);
    repeat (3) tick();
    check("wrap_run_stall", 32'(rename_stall), 32'd0);

    // Mispredict with a simultaneous alloc request, then an older mispredict in RECOVER.
    resolve(2'd2, 1'b0);
    alloc(1, 3);
    resolve(2'd3, 1'b0);
    alloc(3, 0);
    check("prio_busy", 32'(busy_mask), 32'h7);
    br_alloc_valid     = 1'b1;
    resolve_valid      = 1'b1;
    resolve_tag        = 2'd2;
    resolve_mispredict = 1'b1;
    #1;
    check("prio_ready", 32'(br_alloc_ready), 32'd0);
    check("prio_ckpt", 32'(rmt_checkpoint), 32'd0);
    push_kill(4'b0100, 2'd2);
    tick();
    resolve_valid      = 1'b0;
    resolve_mispredict = 1'b0;
    br_alloc_valid     = 1'b0;
    tick();
    check("nested_in_recover", 32'(rename_stall), 32'd1);
    push_kill(4'b0011, 2'd0);
    resolve(2'd0, 1'b1);
    check("nested_restore", 32'(rmt_restore), 32'd1);
    check("nested_busy", 32'(busy_mask), 32'h0);
    repeat (3) tick();
    alloc(1, 0);

    // Resolves on non-busy tags change nothing.
    resolve(2'd2, 1'b1);
    check("nb_mp_busy", 32'(busy_mask), 32'h1);
    check("nb_mp_stall", 32'(rename_stall), 32'd0);
    check("nb_mp_kill", 32'(kill_valid), 32'd0);
    resolve(2'd3, 1'b0);
    check("nb_ok_busy", 32'(busy_mask), 32'h1);
    check("nb_ok_ready", 32'(br_alloc_ready), 32'd1);
    alloc(1, 1);
    check("nb_tail_busy", 32'(busy_mask), 32'h3);

    // Asynchronous reset in the middle of RECOVER.
    push_kill(4'b0011, 2'd0);
    resolve(2'd0, 1'b1);
    tick();
    check("pre_rst_stall", 32'(rename_stall), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_stall", 32'(rename_stall), 32'd0);
    check("arst_kill_valid", 32'(kill_valid), 32'd0);
    check("arst_kill_mask", 32'(kill_mask), 32'h0);
    check("arst_restore", 32'(rmt_restore), 32'd0);
    check("arst_busy", 32'(busy_mask), 32'h0);
    check("arst_pos", 32'(rmt_pos), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(br_alloc_ready), 32'd1);
    tick();

    check("grant_queue_drained", 32'(exp_grant_q.size()), 32'd0);
    check("kill_queue_drained", 32'(exp_kill_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tboom_rmt_checkpoint_ctrl.md
Name: tboom_rmt_checkpoint_ctrl

Overview:
- Allocates, tracks and recovers rename-map-table (RMT) checkpoint slots, one slot per in-flight branch.
- Sits in the rename stage between branch decode/rename and the RMT.
- Drives the RMT checkpoint, restore and slot-position inputs; frees slots on correct resolution.
- On mispredict it sequences restore plus a fixed recovery stall, and broadcasts a kill mask of squashed branch tags.

Parameters:
- CHECKPOINT_DEPTH, 8: number of checkpoint slots / branch tags; power of two, >=2.
- RECOVERY_CYCLES, 2: rename stall cycles after the restore cycle; >=1.
- TAG_W, $clog2(CHECKPOINT_DEPTH): width of a branch tag.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- br_alloc_valid  in  1  renaming branch requests a checkpoint slot
- br_alloc_ready  out  1  slot available and not recovering
- br_alloc_tag  out  TAG_W  slot granted; valid when valid&ready
- resolve_valid  in  1  a branch resolved this cycle
- resolve_tag  in  TAG_W  tag of the resolving branch
- resolve_mispredict  in  1  resolution was a mispredict
- rmt_checkpoint  out  1  to RMT checkpoint input
- rmt_restore  out  1  to RMT restore input
- rmt_pos  out  TAG_W  to RMT checkpoint_restore_pos
- rename_stall  out  1  rename must hold this cycle
- kill_valid  out  1  kill_mask is valid this cycle
- kill_mask  out  CHECKPOINT_DEPTH  branch tags squashed
- busy_mask  out  CHECKPOINT_DEPTH  allocated slots

Behaviour:
- State:
  - busy[DEPTH] bit vector
  - tail pointer (next slot to allocate)
  - FSM {RUN, RESTORE, RECOVER}
  - recovery counter
  - pending restore tag
- Reset (asynchronous): busy=0, tail=0, FSM=RUN, counter=0. All registered outputs are 0; br_alloc_ready=1 once reset deasserts.
- Allocation:
  - br_alloc_ready = (FSM==RUN) & !busy[tail] & !mispredict_accept.
  - br_alloc_tag = tail.
  - On fire (valid&ready), same cycle: rmt_checkpoint=1, rmt_pos=tail.
  - Next edge: busy[tail]<=1, tail<=tail+1 mod DEPTH (natural wrap).
- Full: busy[tail]=1 → ready=0. Allocation is in order; freeing may be out of order, so a hole behind tail does not make the controller non-full.
- Correct resolve (resolve_valid & !mispredict & busy[tag]): busy[tag]<=0 next edge. If busy[tag]==0 the resolve is ignored, with no state change.
- Mispredict accept (resolve_valid & mispredict & busy[tag]), in any FSM state:
  - Squash set = circular range tag .. tail-1 inclusive.
  - Next edge: busy for the squash set <=0, tail<=tag, pending<=tag, FSM<=RESTORE.
  - A mispredict on a non-busy tag is ignored.
- RESTORE (exactly 1 cycle):
  - rmt_restore=1, rmt_pos=pending.
  - kill_valid=1, kill_mask = registered squash set.
  - rename_stall=1; counter<=RECOVERY_CYCLES; next state RECOVER.
- RECOVER:
  - rename_stall=1, ready=0.
  - Counter decrements each cycle; at 1 → RUN.
  - A new accepted mispredict (necessarily an older tag) returns to RESTORE with the new tag.
- RUN: rename_stall=0, rmt_restore=0, kill_valid=0.
- Priority in a single cycle: mispredict accept > allocation (allocation blocked). A correct resolve and an allocation in the same cycle are both applied. Allocation into the slot freed this same cycle is not allowed; ready uses current-cycle busy.
- rmt_restore, kill_* and rename_stall come from registers. rmt_checkpoint, br_alloc_ready and rmt_pos-in-RUN are combinational from state and inputs.
- busy_mask = busy register.

Optional Feature:
- Macro TBOOM_CKPT_PERF_EN.
- Defined:
  - Adds outputs perf_mispredicts[31:0], incremented per accepted mispredict.
  - Adds perf_full_stalls[31:0], incremented per cycle with br_alloc_valid & busy[tail] & FSM==RUN.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package tboom_rename_pkg holds:
  - CHECKPOINT_DEPTH and the tag width constant
  - typedef br_tag_t
  - typedef br_mask_t
  - enum ckpt_state_e {RUN, RESTORE, RECOVER}
- One sub-module, tboom_circ_range_mask: combinational; given start, end and DEPTH it produces the circular inclusive-exclusive bit mask. It is reused by the branch-mask logic elsewhere in rename.

Test Plan (DEPTH=4, RECOVERY_CYCLES=2):
- Allocate 4 branches back-to-back → tags 0,1,2,3 with rmt_checkpoint pulsing each cycle; then busy_mask=4'b1111 and br_alloc_ready=0 with valid held.
- Full; correct-resolve tag 0 → next cycle ready=1, tag 0 granted; resolve tag 2 out of order while tail=1 (busy[1]=1) → ready stays 0.
- Tags 0-3 allocated, tail=0; mispredict tag 1 → next cycle rmt_restore=1, rmt_pos=1, kill_mask=4'b1110, tail=1. Stall holds 3 cycles total, then RUN and tag 1 is next granted.
- Wrap case: tail=1, busy=4'b1101 (tags 2,3,0); mispredict tag 3 → kill_mask=4'b1001, tail=3.
- Mispredict together with alloc valid the same cycle → no grant, no rmt_checkpoint. A second mispredict on tag 0 during RECOVER → re-enters RESTORE with rmt_pos=0.
- Resolve on a non-busy tag (mispredict or correct) → no state or output change. Assert rst mid-RECOVER → all outputs 0 and busy=0 immediately, asynchronously.
